// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH+1-bit add per cycle,
// WIDTH cycles per product, start/busy/done handshake.
module seq_mult_shift_add #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
      $error("seq_mult_shift_add: need WIDTH >= 2 and 2**CNT_W > WIDTH");
    end
  endgenerate

  logic [0:0]           state_reg,   state_next;
  logic [WIDTH-1:0]     mcand_reg,   mcand_next;
  logic [WIDTH-1:0]     mplier_reg,  mplier_next;
  logic [2*WIDTH-1:0]   acc_reg,     acc_next;
  logic [CNT_W-1:0]     cnt_reg,     cnt_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic                 done_reg,    done_next;

  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;

  // One iteration: add into the upper half, then shift {carry, acc} right.
  always_comb begin
    addend   = mplier_reg[0] ? {1'b0, mcand_reg} : '0;
    sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + addend;
    acc_step = {sum, acc_reg[WIDTH-1:1]};
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next  = a;
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_next    = acc_step;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_ITER) begin
          product_next = acc_step;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add (WIDTH=5): directed cases,
// randomized operations and an exhaustive back-to-back sweep against a*b.
module tb_seq_mult_shift_add;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mult_shift_add #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns 1ns after that edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); performs no checks itself.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 5'd31; b = 5'd31;
    tick(); tick();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (product !== '0) begin bad++; $display("FAIL reset_product: got %0d expected 0", product); end
    rst = 1'b0;
    tick();
    $display("reset: busy=%0b done=%0b product=%0d", busy, done, product);
  endtask

  task automatic test_basic();
    launch(5'd21, 5'd13);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_k: got %0b expected 1", busy); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL basic_run_edge%0d: got busy=%0b done=%0b expected busy=1 done=0", i, busy, done);
      end
    end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done_edge5: got busy=%0b done=%0b expected busy=0 done=1", busy, done);
    end
    total++; if (product !== 10'd273) begin bad++; $display("FAIL basic_product: got %0d expected 273", product); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %0b expected 0", done); end
    total++; if (product !== 10'd273) begin bad++; $display("FAIL basic_product_hold: got %0d expected 273", product); end
    $display("op a=21 b=13 product=%0d", product);
  endtask

  task automatic test_carry_and_zero();
    logic [W-1:0]   xs [3] = '{5'd31, 5'd0, 5'd19};
    logic [W-1:0]   ys [3] = '{5'd31, 5'd27, 5'd0};
    logic [2*W-1:0] exp_p;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      exp_p = (2*W)'(int'(xs[i]) * int'(ys[i]));
      launch(xs[i], ys[i]);
      wait_done(cyc);
      total++; if (cyc != W) begin bad++; $display("FAIL edge_latency[%0d]: got %0d expected %0d", i, cyc, W); end
      total++; if (product !== exp_p) begin bad++; $display("FAIL edge_product[%0d]: got %0d expected %0d", i, product, exp_p); end
      $display("op a=%0d b=%0d product=%0d cycles=%0d", xs[i], ys[i], product, cyc);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(5'd7, 5'd9);
    start = 1'b1; a = 5'd3; b = 5'd3;   // held through the rest of the run
    tick();
    wait_done(cyc);
    total++; if (cyc != W - 1) begin bad++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, W - 1); end
    total++; if (product !== 10'd63) begin bad++; $display("FAIL b2b_ignore_product: got %0d expected 63", product); end
    $display("op a=7 b=9 product=%0d (start while busy ignored)", product);
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %0b expected 1", busy); end
    cyc = 0;
    while (!done && cyc < 50) begin
      total++; if (product !== 10'd63) begin bad++; $display("FAIL b2b_hold_product: got %0d expected 63", product); end
      tick();
      cyc++;
    end
    total++; if (cyc != W) begin bad++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, W); end
    total++; if (product !== 10'd9) begin bad++; $display("FAIL b2b_second_product: got %0d expected 9", product); end
    $display("op a=3 b=3 product=%0d (back-to-back)", product);
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    launch(5'd25, 5'd30);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    total++; if (product !== '0) begin bad++; $display("FAIL midrst_product: got %0d expected 0", product); end
    for (int i = 0; i < 8; i++) begin
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %0b expected 0 at cycle %0d", done, i); end
      tick();
    end
    launch(5'd2, 5'd2);
    wait_done(cyc);
    total++; if (cyc != W) begin bad++; $display("FAIL midrst_next_latency: got %0d expected %0d", cyc, W); end
    total++; if (product !== 10'd4) begin bad++; $display("FAIL midrst_next_product: got %0d expected 4", product); end
    $display("op a=25 b=30 aborted by reset; op a=2 b=2 product=%0d", product);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0]   x, y;
    logic [2*W-1:0] prev, exp_p;
    int cyc;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      x = W'($urandom_range(0, 31));
      y = W'($urandom_range(0, 31));
      exp_p = (2*W)'(int'(x) * int'(y));
      prev = product;
      launch(x, y);
      cyc = 0;
      while (!done && cyc < 50) begin
        a = W'($urandom);
        b = W'($urandom);
        start = (cyc < W - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        total++; if (product !== prev) begin bad++; $display("FAIL rand_product_stable[%0d]: got %0d expected %0d", n, product, prev); end
        tick();
        cyc++;
      end
      start = 1'b0;
      total++; if (cyc != W) begin bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, cyc, W); end
      total++; if (product !== exp_p) begin bad++; $display("FAIL rand_product[%0d] a=%0d b=%0d: got %0d expected %0d", n, x, y, product, exp_p); end
      $display("op a=%0d b=%0d product=%0d cycles=%0d", x, y, product, cyc);
      tick();
    end
  endtask

  task automatic test_sweep();
    int cx, cy, cyc;
    int errs_before;
    errs_before = bad;
    cx = 0; cy = 0;
    launch(W'(cx), W'(cy));
    for (int i = 0; i < 1024; i++) begin
      wait_done(cyc);
      total++; if (cyc != W) begin bad++; $display("FAIL sweep_latency a=%0d b=%0d: got %0d expected %0d", cx, cy, cyc, W); end
      total++; if (product !== (2*W)'(cx * cy)) begin
        bad++; $display("FAIL sweep_product a=%0d b=%0d: got %0d expected %0d", cx, cy, product, cx * cy);
      end
      if (cyc >= 50) break;
      if (i < 1023) begin
        cx = (i + 1) >> 5;
        cy = (i + 1) & 31;
        launch(W'(cx), W'(cy));
      end
    end
    tick();
    $display("sweep: 1024 back-to-back ops, new errors=%0d", bad - errs_before);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_carry_and_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
